// File: rtl/o_normalize.sv
// o_normalize: divides an accumulated O* vector by its denominator lane l.
// A bit-serial restoring divider forms recip = 2^(2*FRAC) / l, then each
// numerator lane is multiplied by recip, shifted back into Q format and
// saturated. One result is held in DONE until the downstream stage takes it.

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif

module o_normalize #(
   parameter int DIM  = `MAX_EMBEDDING_DIM,
   parameter int DW   = 16,
   parameter int FRAC = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  vld_in,
   output logic                  rdy_out,
   input  logic [(DIM+1)*DW-1:0] star_in,
   output logic                  vld_out,
   input  logic                  rdy_in,
   output logic [DIM*DW-1:0]     o_out,
   output logic                  div_err
);

   // Quotient width: 2^(2*FRAC) needs 2*FRAC+1 bits (l = 1 gives the full value).
   localparam int RW = 2*FRAC + 1;
   // Full product width: signed lane times zero-extended unsigned recip.
   localparam int PW = DW + RW + 1;
   // Lane index runs 0..DIM; the extra count drains the multiply pipeline.
   localparam int IW = (DIM + 1 > 1) ? $clog2(DIM + 1) : 1;
   localparam int CW = $clog2(RW);

   localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      RECIP,
      SCALE,
      DONE
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic signed [DW-1:0] r_lane [DIM+1];
   logic signed [DW-1:0] r_out  [DIM];
   logic [IW-1:0]        r_laneIdx;
   logic [CW-1:0]        r_bitCnt;
   logic [DW:0]          r_rem;
   logic [RW-1:0]        r_dividend;
   logic [RW-1:0]        r_recip;
   logic signed [PW-1:0] r_prod;
   logic                 r_err;

   logic                 w_accept;
   logic                 w_lPos;
   logic [DW+1:0]        w_trial;
   logic [DW+1:0]        w_sub;
   logic                 w_ge;
   logic signed [DW-1:0] w_lane;
   logic signed [PW-1:0] w_prod;
   logic signed [PW-1:0] w_shift;
   logic signed [DW-1:0] w_sat;

   // A vector is taken whenever upstream offers one and we advertise ready.
   assign w_accept = vld_in && rdy_out;

   // The denominator on the input port is usable only if strictly positive.
   assign w_lPos = !star_in[(DIM+1)*DW-1] && (star_in[DIM*DW +: DW] != '0);

   // Restoring-division step: bring down the next dividend bit and try to subtract l.
   assign w_trial = {r_rem, r_dividend[RW-1]};
   assign w_sub   = w_trial - {2'b00, r_lane[DIM]};
   assign w_ge    = (w_trial >= {2'b00, r_lane[DIM]});

   // Select the numerator lane addressed by the current lane index.
   always_comb begin
      w_lane = '0;
      for (int i = 0; i < DIM; i++) begin
         if (r_laneIdx == IW'(i)) begin
            w_lane = r_lane[i];
         end
      end
   end

   // Full-width signed product of the selected lane and the positive reciprocal.
   assign w_prod = PW'(w_lane) * PW'($signed({1'b0, r_recip}));

   // Shift the registered product back to Q format (floor) and clamp to the lane range.
   always_comb begin
      w_shift = r_prod >>> FRAC;
      w_sat   = DW'(w_shift);
      if (w_shift > SAT_MAX) begin
         w_sat = {1'b0, {(DW-1){1'b1}}};
      end else if (w_shift < SAT_MIN) begin
         w_sat = {1'b1, {(DW-1){1'b0}}};
      end
   end

   // State register; reset always wins over any handshake in the same cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and handshake decode; DONE can hand off and reload in one cycle.
   always_comb begin
      w_nextState = r_state;
      rdy_out     = 1'b0;
      vld_out     = 1'b0;
      case (r_state)
         IDLE: begin
            rdy_out = 1'b1;
            if (vld_in) begin
               w_nextState = w_lPos ? RECIP : SCALE;
            end
         end
         RECIP: begin
            if (r_bitCnt == CW'(RW - 1)) begin
               w_nextState = SCALE;
            end
         end
         SCALE: begin
            if (r_laneIdx == IW'(DIM)) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            vld_out = 1'b1;
            rdy_out = rdy_in;
            if (rdy_in) begin
               if (vld_in) begin
                  w_nextState = w_lPos ? RECIP : SCALE;
               end else begin
                  w_nextState = IDLE;
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Datapath: capture on accept, shift out quotient bits in RECIP, then scale
   // lanes through a two-stage multiply/saturate pipeline in SCALE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         r_laneIdx  <= '0;
         r_bitCnt   <= '0;
         r_rem      <= '0;
         r_dividend <= '0;
         r_recip    <= '0;
         r_prod     <= '0;
         r_err      <= 1'b0;
         for (int i = 0; i <= DIM; i++) begin
            r_lane[i] <= '0;
         end
         for (int i = 0; i < DIM; i++) begin
            r_out[i] <= '0;
         end
      end else if (w_accept) begin
         for (int i = 0; i <= DIM; i++) begin
            r_lane[i] <= star_in[i*DW +: DW];
         end
         r_laneIdx  <= '0;
         r_bitCnt   <= '0;
         r_rem      <= '0;
         r_dividend <= {1'b1, {(RW-1){1'b0}}};
         r_recip    <= '0;
         r_err      <= !w_lPos;
      end else begin
         case (r_state)
            RECIP: begin
               r_rem      <= (DW+1)'(w_ge ? w_sub : w_trial);
               r_recip    <= {r_recip[RW-2:0], w_ge};
               r_dividend <= {r_dividend[RW-2:0], 1'b0};
               r_bitCnt   <= r_bitCnt + CW'(1);
            end
            SCALE: begin
               if (r_laneIdx != IW'(DIM)) begin
                  r_prod    <= w_prod;
                  r_laneIdx <= r_laneIdx + IW'(1);
               end
               for (int i = 0; i < DIM; i++) begin
                  if (r_laneIdx == IW'(i + 1)) begin
                     r_out[i] <= w_sat;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Pack the registered result lanes onto the output bus.
   always_comb begin
      o_out = '0;
      for (int i = 0; i < DIM; i++) begin
         o_out[i*DW +: DW] = r_out[i];
      end
   end

   assign div_err = r_err;

endmodule
